sp_ram_sync_ctrl: RTL

//  Initiator-side controller for the single-port synchronous RAM. Converts a valid/ready beat stream
//  (one read or write per beat) into the RAM's address/data/cs/we/oe pins and returns read data in order.

---
 rtl/sp_ram_sync_ctrl_if.sv | 27 ++
 rtl/sp_ram_sync_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/sp_ram_sync_ctrl_if.sv
// Client-side beat interface for the single-port synchronous RAM controller.
interface sp_ram_sync_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  // Client side: issues beats, receives read data.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Controller side: accepts beats, returns read data.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sp_ram_sync_ctrl.sv
// Initiator-side controller for a single-port synchronous RAM: turns a valid/ready
// beat stream into registered RAM pins and returns read data in request order.
// Every read<->write bus direction change passes through a one-cycle TURN state.
module sp_ram_sync_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sp_ram_sync_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  localparam int unsigned RD_PIPE_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_TAIL,
    S_TURN
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   ready_c;
  logic                   accept_c;
  logic                   accept_rd_c;
  logic                   accept_wr_c;
  logic                   drive_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [RD_PIPE_W-1:0]   rd_pipe_q;

  // Next-state and ready decode; reads and writes never share a state.
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) state_d = bus.req_we ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        ready_c = bus.req_we;
        if (bus.req_valid) state_d = bus.req_we ? S_WRITE : S_TURN;
        else               state_d = S_IDLE;
      end
      S_READ: begin
        ready_c = !bus.req_we;
        if (bus.req_valid && !bus.req_we) state_d = S_READ;
        else                              state_d = S_TAIL;
      end
      S_TAIL: begin
        ready_c = !bus.req_we;
        if (bus.req_valid) state_d = bus.req_we ? S_TURN : S_READ;
        else               state_d = S_IDLE;
      end
      S_TURN: begin
        ready_c = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        ready_c = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    if (!rst_n) ready_c = 1'b0;
  end

  assign accept_c    = bus.req_valid && ready_c;
  assign accept_rd_c = accept_c && !bus.req_we;
  assign accept_wr_c = accept_c && bus.req_we;
  assign bus.req_ready = ready_c;

  // State register and registered RAM pins, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      drive_q     <= 1'b0;
      ram_address <= '0;
      wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      ram_cs  <= (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_TAIL);
      ram_we  <= (state_d == S_WRITE);
      ram_oe  <= (state_d == S_READ) || (state_d == S_TAIL);
      drive_q <= (state_d == S_WRITE);
      if (accept_c)    ram_address <= bus.req_addr;
      if (accept_wr_c) wdata_q     <= bus.req_wdata;
    end
  end

  // Controller drives the data bus only while in WRITE.
  assign ram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  // Read-valid pipeline: data is on the bus two edges after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pipe_q     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      rd_pipe_q     <= {rd_pipe_q[0], accept_rd_c};
      bus.rsp_valid <= rd_pipe_q[1];
      if (rd_pipe_q[1]) bus.rsp_rdata <= ram_data;
    end
  end

endmodule
